// File: rtl/rect_bounce_animator_pkg.sv
// Shared FSM encoding, coordinate width and default 720p geometry
// for the bouncing-rectangle animator.
package rect_bounce_animator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      HIT  = 2'd2
   } state_t;

   localparam int COORD_W = 12;

   localparam int DEF_H_ACTIVE   = 1280;
   localparam int DEF_V_ACTIVE   = 720;
   localparam int DEF_BOX_W      = 64;
   localparam int DEF_BOX_H      = 48;
   localparam int DEF_HIT_FRAMES = 8;

endpackage

// File: rtl/rect_axis_step.sv
// One-axis position update: steps the coordinate by 'step' in its direction,
// clamps against 0 or 'limit' (touching counts) and flips the direction on a clamp.
module rect_axis_step
   import rect_bounce_animator_pkg::*;
#(
   parameter int W = COORD_W
) (
   input  logic [W-1:0] pos,
   input  logic         dir,
   input  logic [3:0]   step,
   input  logic [W-1:0] limit,
   output logic [W-1:0] next_pos,
   output logic         next_dir,
   output logic         clamp
);

   logic signed [W:0] pos_s;
   logic signed [W:0] step_s;
   logic signed [W:0] lim_s;
   logic signed [W:0] prop;
   logic              hit_hi;
   logic              hit_lo;

   assign pos_s  = {1'b0, pos};
   assign step_s = {{(W-3){1'b0}}, step};
   assign lim_s  = {1'b0, limit};

   // One extra bit keeps the proposed value from wrapping in either direction
   assign prop   = dir ? (pos_s + step_s) : (pos_s - step_s);

   assign hit_hi = dir  && (prop >= lim_s);
   assign hit_lo = !dir && (prop[W] || (prop == '0));
   assign clamp  = (step != 4'd0) && (hit_hi || hit_lo);

   always_comb begin
      next_pos = prop[W-1:0];
      next_dir = dir;
      if (clamp) begin
         next_pos = dir ? limit : '0;
         next_dir = ~dir;
      end
   end

endmodule

// File: rtl/rect_bounce_animator.sv
// Frame-rate rectangle animator: moves a box diagonally, bounces off the
// screen edges, blinks for a few frames after each bounce and counts bounces.
module rect_bounce_animator
   import rect_bounce_animator_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int BOX_W      = DEF_BOX_W,
   parameter int BOX_H      = DEF_BOX_H,
   parameter int HIT_FRAMES = DEF_HIT_FRAMES
) (
   input  logic        pixclk,
   input  logic        rst,
   input  logic        i_animate,
   input  logic        go_animate,
   input  logic [3:0]  speed,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2,
   output logic        display,
   output logic [7:0]  bounce_cnt
);

   localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(H_ACTIVE - BOX_W);
   localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(V_ACTIVE - BOX_H);
   localparam logic [COORD_W-1:0] X_HOME   = COORD_W'((H_ACTIVE - BOX_W) / 2);
   localparam logic [COORD_W-1:0] Y_HOME   = COORD_W'((V_ACTIVE - BOX_H) / 2);
   localparam logic [COORD_W-1:0] BW       = COORD_W'(BOX_W);
   localparam logic [COORD_W-1:0] BH       = COORD_W'(BOX_H);
   localparam logic [3:0]         HIT_LAST = 4'(HIT_FRAMES - 1);

   state_t             state;
   logic               dx;
   logic               dy;
   logic [3:0]         hit_cnt;
   logic [COORD_W-1:0] nx;
   logic [COORD_W-1:0] ny;
   logic               ndx;
   logic               ndy;
   logic               cx;
   logic               cy;

   rect_axis_step #(.W(COORD_W)) u_step_x (
      .pos      (o_x1),
      .dir      (dx),
      .step     (speed),
      .limit    (X_LIM),
      .next_pos (nx),
      .next_dir (ndx),
      .clamp    (cx)
   );

   rect_axis_step #(.W(COORD_W)) u_step_y (
      .pos      (o_y1),
      .dir      (dy),
      .step     (speed),
      .limit    (Y_LIM),
      .next_pos (ny),
      .next_dir (ndy),
      .clamp    (cy)
   );

   always_ff @(posedge pixclk) begin
      if (rst) begin
         state      <= IDLE;
         o_x1       <= X_HOME;
         o_x2       <= X_HOME + BW;
         o_y1       <= Y_HOME;
         o_y2       <= Y_HOME + BH;
         dx         <= 1'b1;
         dy         <= 1'b1;
         display    <= 1'b1;
         bounce_cnt <= 8'd0;
         hit_cnt    <= 4'd0;
      end else if ((state != IDLE) && !go_animate) begin
         // Motion enable drops take effect immediately, not at the next frame
         state   <= IDLE;
         hit_cnt <= 4'd0;
         display <= 1'b1;
      end else if (i_animate) begin
         case (state)
            IDLE: begin
               if (go_animate) state <= MOVE;
            end
            MOVE: begin
               o_x1 <= nx;
               o_x2 <= nx + BW;
               o_y1 <= ny;
               o_y2 <= ny + BH;
               dx   <= ndx;
               dy   <= ndy;
               if (cx || cy) begin
                  bounce_cnt <= bounce_cnt + 8'd1;
                  state      <= HIT;
                  display    <= 1'b0;
               end
            end
            HIT: begin
               if (hit_cnt == HIT_LAST) begin
                  state   <= MOVE;
                  display <= 1'b1;
                  hit_cnt <= 4'd0;
               end else begin
                  hit_cnt <= hit_cnt + 4'd1;
                  display <= ~display;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rect_bounce_animator.sv
// Bench for rect_bounce_animator: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed positions.
module tb_rect_bounce_animator;

   localparam int XL = 1216;
   localparam int YL = 672;
   localparam int BW = 64;
   localparam int BH = 48;
   localparam int HF = 8;
   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_HIT  = 2;

   logic        pixclk = 1'b0;
   logic        rst;
   logic        i_animate;
   logic        go_animate;
   logic [3:0]  speed;
   logic [11:0] o_x1, o_x2, o_y1, o_y2;
   logic        display;
   logic [7:0]  bounce_cnt;

   always #5 pixclk = ~pixclk;

   rect_bounce_animator dut (
      .pixclk     (pixclk),
      .rst        (rst),
      .i_animate  (i_animate),
      .go_animate (go_animate),
      .speed      (speed),
      .o_x1       (o_x1),
      .o_x2       (o_x2),
      .o_y1       (o_y1),
      .o_y2       (o_y2),
      .display    (display),
      .bounce_cnt (bounce_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Reference state, tracked in plain integers
   bit m_valid = 1'b0;
   int m_mode, m_x, m_y, m_dx, m_dy, m_disp, m_hit, m_bounces;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // New coordinate after moving s pixels; touching or passing either edge clamps
   function automatic int step_axis(input int p, input int s, input int dir,
                                    input int lim, output bit hit);
      int np;
      hit = 1'b0;
      if (s == 0) return p;
      np = (dir != 0) ? p + s : p - s;
      if (np >= lim) begin hit = 1'b1; return lim; end
      if (np <= 0)   begin hit = 1'b1; return 0;   end
      return np;
   endfunction

   task automatic model_edge();
      bit hx, hy;
      int nx, ny;
      if (rst) begin
         m_valid = 1'b1; m_mode = M_IDLE; m_x = 608; m_y = 336;
         m_dx = 1; m_dy = 1; m_disp = 1; m_hit = 0; m_bounces = 0;
      end else if (!m_valid) begin
         m_valid = 1'b0;
      end else if (m_mode != M_IDLE && go_animate == 1'b0) begin
         m_mode = M_IDLE; m_hit = 0; m_disp = 1;
      end else if (i_animate) begin
         if (m_mode == M_IDLE) begin
            if (go_animate) m_mode = M_MOVE;
         end else if (m_mode == M_MOVE) begin
            nx = step_axis(m_x, int'(speed), m_dx, XL, hx);
            ny = step_axis(m_y, int'(speed), m_dy, YL, hy);
            m_x = nx; m_y = ny;
            if (hx) m_dx = 1 - m_dx;
            if (hy) m_dy = 1 - m_dy;
            if (hx || hy) begin m_bounces++; m_mode = M_HIT; m_disp = 0; end
         end else begin
            m_hit++;
            if (m_hit == HF) begin m_mode = M_MOVE; m_disp = 1; m_hit = 0; end
            else m_disp = 1 - m_disp;
         end
      end
   endtask

   initial forever begin
      @(posedge pixclk);
      model_edge();
   end

   initial forever begin
      @(negedge pixclk);
      if (m_valid) begin
         check("x1", int'(o_x1), m_x);
         check("x2", int'(o_x2), m_x + BW);
         check("y1", int'(o_y1), m_y);
         check("y2", int'(o_y2), m_y + BH);
         check("display", int'(display), m_disp);
         check("bounce_cnt", int'(bounce_cnt), m_bounces % 256);
      end
   end

   // One frame pulse; speed is scrambled afterwards to show it is only sampled on the pulse
   task automatic pulse(input int s);
      @(negedge pixclk);
      speed = 4'(s);
      i_animate = 1'b1;
      @(negedge pixclk);
      i_animate = 1'b0;
      speed = ~4'(s);
   endtask

   task automatic do_reset();
      @(negedge pixclk);
      rst = 1'b1;
      @(negedge pixclk);
      rst = 1'b0;
   endtask

   task automatic check_pos(input string name, input int ex, input int ey);
      check({name, "_x1"}, int'(o_x1), ex);
      check({name, "_y1"}, int'(o_y1), ey);
   endtask

   int ex4[4] = '{608, 612, 616, 620};
   int ey4[4] = '{336, 340, 344, 348};

   initial begin
      int n;
      rst = 1'b1; i_animate = 1'b0; go_animate = 1'b0; speed = 4'd0;
      repeat (2) @(negedge pixclk);
      rst = 1'b0;
      check_pos("reset", 608, 336);
      check("reset_x2", int'(o_x2), 672);
      check("reset_y2", int'(o_y2), 384);
      check("reset_disp", int'(display), 1);
      check("reset_bcnt", int'(bounce_cnt), 0);

      pulse(7); pulse(7);
      check_pos("idle_pulses", 608, 336);

      go_animate = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse(4);
         check_pos($sformatf("speed4_p%0d", i + 1), ex4[i], ey4[i]);
      end
      check("speed4_x2", int'(o_x2), 684);

      do_reset();
      repeat (24) pulse(15);
      check_pos("first_bounce", 953, 672);
      check("first_bounce_disp", int'(display), 0);
      check("first_bounce_bcnt", int'(bounce_cnt), 1);
      for (int i = 0; i < 8; i++) begin
         pulse(15);
         check_pos($sformatf("hit_p%0d", i + 1), 953, 672);
         check($sformatf("hit_disp_p%0d", i + 1), int'(display),
               (i == 7) ? 1 : ((i % 2 == 0) ? 1 : 0));
      end
      pulse(15);
      check_pos("after_hit", 968, 657);

      go_animate = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse(15);
         check_pos($sformatf("paused_p%0d", i + 1), 968, 657);
      end
      check("paused_disp", int'(display), 1);
      go_animate = 1'b1;
      pulse(15);
      check_pos("reentry", 968, 657);
      pulse(15);
      check_pos("resumed", 983, 642);

      do_reset();
      repeat (32) pulse(15);
      repeat (3) pulse(0);
      check_pos("speed0_at_limit", 953, 672);
      check("speed0_bcnt", int'(bounce_cnt), 1);

      do_reset();
      repeat (27) pulse(15);
      @(negedge pixclk);
      rst = 1'b1; i_animate = 1'b1; speed = 4'd15;
      @(negedge pixclk);
      rst = 1'b0; i_animate = 1'b0;
      check_pos("rst_mid_hit", 608, 336);
      check("rst_mid_hit_disp", int'(display), 1);
      check("rst_mid_hit_bcnt", int'(bounce_cnt), 0);
      pulse(15);
      check_pos("rst_then_enter", 608, 336);
      pulse(15);
      check_pos("rst_then_move", 623, 351);

      // Steer into the bottom-right corner, then run until the counter wraps
      do_reset();
      n = 0;
      while (!(m_bounces == 5 && m_mode == M_MOVE) && n < 2000) begin pulse(15); n++; end
      check_pos("fifth_bounce", 0, 522);
      check("fifth_bounce_bcnt", int'(bounce_cnt), 5);
      repeat (34) pulse(15);
      pulse(11);
      pulse(15);
      check_pos("sixth_bounce", 536, 0);
      check("sixth_bounce_bcnt", int'(bounce_cnt), 6);
      repeat (8) pulse(15);
      repeat (44) pulse(15);
      pulse(5);
      check_pos("pre_corner", 1201, 665);
      pulse(15);
      check_pos("corner", 1216, 672);
      check("corner_bcnt", int'(bounce_cnt), 7);
      n = 0;
      while (m_bounces < 255 && n < 30000) begin pulse(15); n++; end
      check("bcnt_255", int'(bounce_cnt), 255);
      n = 0;
      while (m_bounces < 256 && n < 2000) begin pulse(15); n++; end
      check("bcnt_wrap", int'(bounce_cnt), 0);
      check("wrap_reached", m_bounces, 256);

      @(negedge pixclk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rect_bounce_animator.md
RECT_BOUNCE_ANIMATOR -- requirements
Module: rect_bounce_animator

Interface
REQ-001 Parameter H_ACTIVE, 1280: visible width in pixels.
REQ-002 Parameter V_ACTIVE, 720: visible height in pixels.
REQ-003 Parameter BOX_W, 64: rectangle width in pixels.
REQ-004 Parameter BOX_H, 48: rectangle height in pixels.
REQ-005 Parameter HIT_FRAMES, 8: length of the post-bounce pause, in frames.
REQ-006 pixclk  in  1  pixel clock; the single clock domain.
REQ-007 rst  in  1  reset; synchronous to pixclk, active-high.
REQ-008 i_animate  in  1  one-cycle pulse per frame, from the sync generator.
REQ-009 go_animate  in  1  motion enable; level-sensitive.
REQ-010 speed  in  4  step size in pixels per frame, for both axes; driven from the dip switches.
REQ-011 o_x1, o_x2  out  12 each  left and right edges of the rectangle; exclusive bounds used by the pixel compare.
REQ-012 o_y1, o_y2  out  12 each  top and bottom edges of the rectangle; exclusive bounds.
REQ-013 display  out  1  rectangle visible flag.
REQ-014 bounce_cnt  out  8  count of bounce events; wraps modulo 256; intended for the LEDs.

Function
REQ-015 The block SHALL evaluate position and state only on a pixclk cycle where i_animate=1; on all other cycles every register SHALL hold its value.
REQ-016 All outputs SHALL be registered; a result SHALL become visible one cycle after the i_animate pulse that caused it.
REQ-017 o_x2 SHALL equal o_x1+BOX_W and o_y2 SHALL equal o_y1+BOX_H at all times.
REQ-018 The FSM SHALL have three states: IDLE, MOVE and HIT.
REQ-019 IDLE -> MOVE on a pulse with go_animate=1; that same pulse SHALL NOT move the box.
REQ-020 MOVE, on a pulse with go_animate=1:
- each axis SHALL move by speed in its direction bit (dx, dy; 1 = increasing);
- the sum SHALL be computed 13 bits wide, so it cannot wrap.
REQ-021 Clamping:
- x1 SHALL be clamped to the range 0..H_ACTIVE-BOX_W;
- y1 SHALL be clamped to the range 0..V_ACTIVE-BOX_H;
- a clamp SHALL occur when the proposed value is beyond a limit or exactly equal to it.
- A clamp SHALL invert that axis's direction bit.
REQ-022 Any clamp, on one or both axes, SHALL:
- increment bounce_cnt by exactly 1;
- enter HIT;
- set display=0.
REQ-023 speed=0 SHALL produce no motion and no clamp, even at a limit.
REQ-024 HIT behaviour:
- position SHALL be frozen;
- each pulse SHALL toggle display and increment a 4-bit frame counter;
- on the HIT_FRAMES-th pulse the block SHALL return to MOVE with display forced to 1 and the counter cleared.
REQ-025 go_animate=0, sampled on any cycle in MOVE or HIT, SHALL cause the next state to be IDLE, with:
- the HIT counter cleared;
- display=1;
- position held.
REQ-026 In IDLE, i_animate pulses SHALL NOT change position or bounce_cnt.
REQ-027 speed SHALL be sampled only on an i_animate pulse; changing it mid-frame SHALL have no effect until the next pulse.

Reset
REQ-028 On a rst=1 cycle the following SHALL take effect at the next edge:
- state=IDLE;
- o_x1=(H_ACTIVE-BOX_W)/2 (608 with defaults);
- o_y1=(V_ACTIVE-BOX_H)/2 (336 with defaults);
- dx=1 and dy=1;
- display=1;
- bounce_cnt=0;
- HIT counter=0.
REQ-029 rst SHALL override i_animate on the same cycle, including when asserted in the middle of HIT.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state encoding;
- the 12-bit coordinate width;
- the default geometry constants.
REQ-031 A sub-module rect_axis_step SHALL compute the next coordinate, the clamp and the direction flip for one axis, taking position, direction, step and limit as inputs; it SHALL be instantiated twice, once for x and once for y.

Verification
REQ-032 Reset; go_animate=1; speed=4; four pulses -> o_x1 = 608, 612, 616, 620 and o_y1 = 336, 340, 344, 348 after pulses 1 to 4; o_x2=684 after pulse 4.
REQ-033 speed=15; from reset, 24 pulses (the first pulse enters MOVE) ->
- o_y1 clamps to 672 and o_x1=953;
- dy=0; state HIT; display=0; bounce_cnt=1.
REQ-034 Continuing from REQ-033:
- 8 further pulses SHALL keep position frozen while display toggles;
- after the 8th of those pulses display=1 and the state is MOVE;
- the next pulse gives o_y1=657.
REQ-035 In MOVE, drop go_animate for 5 pulses, then raise it -> position unchanged through the 5 pulses and through the re-entry pulse; motion resumes on the following pulse.
REQ-036 Assert rst for 1 cycle mid-HIT -> o_x1=608, o_y1=336, display=1, bounce_cnt=0, state IDLE.
REQ-037 Force 256 bounces -> bounce_cnt wraps from 255 to 0; a corner hit (both axes clamp on the same pulse) SHALL add exactly 1.
